// File: rtl/viterbi_pkg.sv
// Shared constants and types for the Viterbi decoder branch-metric datapath.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package viterbi_pkg;

  // Default code: rate 1/2, constraint length 3, 3-bit soft symbols.
  localparam int DEF_N_OUT  = 2;
  localparam int DEF_K      = 3;
  localparam int DEF_SOFT_W = 3;

  // Metric width large enough for n_out symbols at full soft distance,
  // so the hypothesis sum never needs saturation.
  function automatic int bm_width(input int soft_w, input int n_out);
    return soft_w + $clog2(n_out + 1);
  endfunction

  localparam int DEF_BM_W = bm_width(DEF_SOFT_W, DEF_N_OUT);

  typedef logic [DEF_BM_W-1:0] bm_t;

endpackage

// File: rtl/bmu_sym_dist.sv
// Soft distance of one received symbol to an expected '0' and an expected '1'.
// Latency: combinational.
// Backpressure: none (pure datapath cell).
// Ports: sym (offset-binary soft symbol), erase (1 = no information),
//        dist0 / dist1 (distance assuming coded bit 0 / 1, zero when erased).
module bmu_sym_dist #(
  parameter int SOFT_W = 3
) (
  input  logic [SOFT_W-1:0] sym,
  input  logic              erase,
  output logic [SOFT_W-1:0] dist0,
  output logic [SOFT_W-1:0] dist1
);

  // Offset-binary: (2**SOFT_W-1) - sym is simply the bitwise complement.
  assign dist0 = erase ? '0 : sym;
  assign dist1 = erase ? '0 : ~sym;

endmodule

// File: rtl/viterbi_bmu_soft.sv
// Soft-decision branch metric unit with periodic depuncturing, rate 1/N_OUT.
// Latency: 1 cycle from accept to registered metrics.
// Backpressure: single output register; in_ready = !out_valid || out_ready.
// Ports: clk/rst (sync, active-high); in_valid/in_ready/rx_sym/in_erase/
//        frame_start input group; out_valid/out_ready/bm/out_phase output
//        group; erase_cnt saturating count of erased symbols since reset.
module viterbi_bmu_soft
  import viterbi_pkg::*;
#(
  parameter int                            SOFT_W       = 3,
  parameter int                            N_OUT        = 2,
  parameter int                            PUNCT_PERIOD = 1,
  parameter logic [PUNCT_PERIOD*N_OUT-1:0] PUNCT_MASK   = '1,
  localparam int                           BM_W         = bm_width(SOFT_W, N_OUT),
  localparam int                           N_HYP        = 2**N_OUT,
  localparam int                           PH_W         = $clog2(PUNCT_PERIOD + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_OUT*SOFT_W-1:0] rx_sym,
  input  logic [N_OUT-1:0]        in_erase,
  input  logic                    frame_start,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_HYP*BM_W-1:0]   bm,
  output logic [PH_W-1:0]         out_phase,
  output logic [15:0]             erase_cnt
);

  logic                  out_valid_q, out_valid_d;
  logic [N_HYP*BM_W-1:0] bm_q, bm_d;
  logic [PH_W-1:0]       out_phase_q, out_phase_d;
  logic [PH_W-1:0]       phase_q, phase_d;
  logic [15:0]           erase_cnt_q, erase_cnt_d;

  logic                  accept;
  logic [PH_W-1:0]       cur_phase;
  logic [N_OUT-1:0]      mask_sh;
  logic [N_OUT-1:0]      erase_vec;
  logic [SOFT_W-1:0]     dist0 [N_OUT];
  logic [SOFT_W-1:0]     dist1 [N_OUT];
  logic [BM_W-1:0]       hyp_acc;
  logic [N_HYP*BM_W-1:0] bm_sum;
  logic [16:0]           erase_acc;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // A frame start forces this group onto phase 0 of the puncture pattern.
  assign cur_phase = frame_start ? '0 : phase_q;

  // Bring the N_OUT keep-bits of the current phase down to bit 0.
  assign mask_sh = N_OUT'(PUNCT_MASK >> (32'(cur_phase) * N_OUT));

  for (genvar g = 0; g < N_OUT; g++) begin : g_sym
    assign erase_vec[g] = in_erase[g] || !mask_sh[g];

    bmu_sym_dist #(
      .SOFT_W (SOFT_W)
    ) u_dist (
      .sym   (rx_sym[g*SOFT_W +: SOFT_W]),
      .erase (erase_vec[g]),
      .dist0 (dist0[g]),
      .dist1 (dist1[g])
    );
  end

  // Hypothesis h: bit i of h selects which per-symbol distance to add.
  always_comb begin
    bm_sum  = '0;
    hyp_acc = '0;
    for (int h = 0; h < N_HYP; h++) begin
      hyp_acc = '0;
      for (int i = 0; i < N_OUT; i++) begin
        if (((h >> i) & 1) != 0) begin
          hyp_acc = hyp_acc + BM_W'(dist1[i]);
        end else begin
          hyp_acc = hyp_acc + BM_W'(dist0[i]);
        end
      end
      bm_sum[h*BM_W +: BM_W] = hyp_acc;
    end
  end

  // One spare bit catches overflow for saturation.
  assign erase_acc = {1'b0, erase_cnt_q} + 17'($countones(erase_vec));

  always_comb begin
    out_valid_d = out_valid_q;
    bm_d        = bm_q;
    out_phase_d = out_phase_q;
    phase_d     = phase_q;
    erase_cnt_d = erase_cnt_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      out_valid_d = 1'b1;
      bm_d        = bm_sum;
      out_phase_d = cur_phase;
      if (cur_phase == PH_W'(PUNCT_PERIOD - 1)) begin
        phase_d = '0;
      end else begin
        phase_d = cur_phase + PH_W'(1);
      end
      erase_cnt_d = erase_acc[16] ? 16'hFFFF : erase_acc[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      bm_q        <= '0;
      out_phase_q <= '0;
      phase_q     <= '0;
      erase_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      bm_q        <= bm_d;
      out_phase_q <= out_phase_d;
      phase_q     <= phase_d;
      erase_cnt_q <= erase_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign bm        = bm_q;
  assign out_phase = out_phase_q;
  assign erase_cnt = erase_cnt_q;

endmodule
